// File: rtl/mux2x1_rr_arbiter.sv
// Registered 2:1 stream merger with round-robin arbitration; Sel tags the source of Y_data.
// Define MUX2X1_ARB_FIXED_PRIO_EN to make I0 always win contention instead.
module mux2x1_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I0_data,
    input  logic             I0_valid,
    output logic             I0_ready,
    input  logic [WIDTH-1:0] I1_data,
    input  logic             I1_valid,
    output logic             I1_ready,
    output logic [WIDTH-1:0] Y_data,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic             Sel
);

    logic load;
    logic take_i0;
    logic take_i1;

    // Output register can accept a word when empty or being drained this cycle.
    assign load = !Y_valid || Y_ready;

`ifdef MUX2X1_ARB_FIXED_PRIO_EN
    assign I0_ready = !rst && load;
    assign I1_ready = !rst && load && !I0_valid;
`else
    // Sel is the last grant, so the other source is favoured on a tie.
    assign I0_ready = !rst && load && !(I1_valid && !Sel);
    assign I1_ready = !rst && load && !(I0_valid && Sel);
`endif

    assign take_i0 = I0_valid && I0_ready;
    assign take_i1 = I1_valid && I1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_valid <= 1'b0;
            Y_data  <= '0;
            Sel     <= 1'b1;
        end else if (take_i0) begin
            Y_valid <= 1'b1;
            Y_data  <= I0_data;
            Sel     <= 1'b0;
        end else if (take_i1) begin
            Y_valid <= 1'b1;
            Y_data  <= I1_data;
            Sel     <= 1'b1;
        end else if (Y_ready) begin
            Y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Self-checking bench for mux2x1_rr_arbiter: per-cycle model compare plus directed literal checks.
// Honours MUX2X1_ARB_FIXED_PRIO_EN when defined at build time.
module tb_mux2x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] I0_data = '0;
    logic       I0_valid = 1'b0;
    logic       I0_ready;
    logic [7:0] I1_data = '0;
    logic       I1_valid = 1'b0;
    logic       I1_ready;
    logic [7:0] Y_data;
    logic       Y_valid;
    logic       Y_ready = 1'b0;
    logic       Sel;

    int total = 0;
    int bad = 0;

    mux2x1_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .I0_data(I0_data), .I0_valid(I0_valid), .I0_ready(I0_ready),
        .I1_data(I1_data), .I1_valid(I1_valid), .I1_ready(I1_ready),
        .Y_data(Y_data), .Y_valid(Y_valid), .Y_ready(Y_ready),
        .Sel(Sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an output slot that is either empty or holds (word, source), plus the last winner.
    logic       m_full = 1'b0;
    logic [7:0] m_word = '0;
    logic       m_src  = 1'b1;
    logic       m_last = 1'b1;

    // Source that wins a tie this cycle.
    function automatic logic favoured();
`ifdef MUX2X1_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return (m_last == 1'b0) ? 1'b1 : 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_ready();
        logic room;
        logic r0;
        logic r1;
        room = !m_full || Y_ready;
        r0 = !rst && room && !(I1_valid && favoured() == 1'b1);
        r1 = !rst && room && !(I0_valid && favoured() == 1'b0);
        return {r1, r0};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] r;
        if (rst) begin
            m_full = 1'b0;
            m_word = '0;
            m_src  = 1'b1;
            m_last = 1'b1;
        end else begin
            r = exp_ready();
            if (I0_valid && r[0]) begin
                m_full = 1'b1; m_word = I0_data; m_src = 1'b0; m_last = 1'b0;
            end else if (I1_valid && r[1]) begin
                m_full = 1'b1; m_word = I1_data; m_src = 1'b1; m_last = 1'b1;
            end else if (Y_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Per-cycle compare and log of every word the consumer takes from Y.
    logic [7:0] got_data[$];
    logic       got_sel[$];
    int         got_cyc[$];
    int         cyc = 0;

    always @(negedge clk) begin
        logic [1:0] r;
        cyc++;
        r = exp_ready();
        check("cyc_y_valid", Y_valid, m_full);
        check("cyc_i0_ready", I0_ready, r[0]);
        check("cyc_i1_ready", I1_ready, r[1]);
        if (m_full) begin
            check("cyc_y_data", Y_data, m_word);
            check("cyc_sel", Sel, m_src);
        end
        if (Y_valid && Y_ready) begin
            got_data.push_back(Y_data);
            got_sel.push_back(Sel);
            got_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_data[$];
    logic       exp_sel[$];

    initial begin
        logic g0;
        logic g1;

        // Reset state.
        repeat (2) step();
        check("rst_y_valid", Y_valid, 1'b0);
        check("rst_y_data", Y_data, 8'h00);
        check("rst_sel", Sel, 1'b1);
        check("rst_i0_ready", I0_ready, 1'b0);
        check("rst_i1_ready", I1_ready, 1'b0);
        rst = 1'b0;
        step();

        // I1-only stream, 0x01..0x08.
        Y_ready  = 1'b1;
        I1_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            I1_data = 8'(k);
            @(negedge clk); #1;
            check("stream_i1_ready", I1_ready, 1'b1);
            step();
            exp_data.push_back(8'(k));
            exp_sel.push_back(1'b1);
        end

        // Continuous contention.
        I0_valid = 1'b1; I0_data = 8'hA0;
        I1_valid = 1'b1; I1_data = 8'hB0;
        repeat (6) begin
            @(negedge clk); #1;
            g0 = I0_valid && I0_ready;
            g1 = I1_valid && I1_ready;
            step();
            if (g0) I0_data++;
            if (g1) I1_data++;
        end
`ifdef MUX2X1_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 6; k++) begin
            exp_data.push_back(8'hA0 + 8'(k)); exp_sel.push_back(1'b0);
        end
`else
        for (int k = 0; k < 3; k++) begin
            exp_data.push_back(8'hA0 + 8'(k)); exp_sel.push_back(1'b0);
            exp_data.push_back(8'hB0 + 8'(k)); exp_sel.push_back(1'b1);
        end
`endif
        I0_valid = 1'b0; I1_valid = 1'b0;
        step();

        // Backpressure with both sources pending.
        Y_ready = 1'b0;
        I0_valid = 1'b1; I0_data = 8'hC0;
        step();
        I0_data = 8'hC1;
        I1_valid = 1'b1; I1_data = 8'hD0;
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_y_data", Y_data, 8'hC0);
            check("bp_sel", Sel, 1'b0);
            check("bp_i0_ready", I0_ready, 1'b0);
            check("bp_i1_ready", I1_ready, 1'b0);
            step();
        end
        Y_ready = 1'b1;
        step();
        exp_data.push_back(8'hC0); exp_sel.push_back(1'b0);
        I0_valid = 1'b0; I1_valid = 1'b0; Y_ready = 1'b0;
        check("refill_y_valid", Y_valid, 1'b1);
`ifdef MUX2X1_ARB_FIXED_PRIO_EN
        check("refill_y_data", Y_data, 8'hC1);
        check("refill_sel", Sel, 1'b0);
`else
        check("refill_y_data", Y_data, 8'hD0);
        check("refill_sel", Sel, 1'b1);
`endif
        step();

        // Drain without refill.
        Y_ready = 1'b1;
        step();
        Y_ready = 1'b0;
`ifdef MUX2X1_ARB_FIXED_PRIO_EN
        exp_data.push_back(8'hC1); exp_sel.push_back(1'b0);
        check("drain_y_data", Y_data, 8'hC1);
        check("drain_sel", Sel, 1'b0);
`else
        exp_data.push_back(8'hD0); exp_sel.push_back(1'b1);
        check("drain_y_data", Y_data, 8'hD0);
        check("drain_sel", Sel, 1'b1);
`endif
        check("drain_y_valid", Y_valid, 1'b0);
        step();

        // Mid-operation reset with a word held.
        I0_valid = 1'b1; I0_data = 8'h55;
        step();
        I0_valid = 1'b0;
        check("pre_rst_y_valid", Y_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_y_valid", Y_valid, 1'b0);
        check("midrst_y_data", Y_data, 8'h00);
        check("midrst_sel", Sel, 1'b1);
        check("midrst_i0_ready", I0_ready, 1'b0);
        check("midrst_i1_ready", I1_ready, 1'b0);
        step();
        I0_valid = 1'b1; I0_data = 8'h11;
        rst = 1'b0;
        step();
        I0_valid = 1'b0;
        check("post_rst_y_valid", Y_valid, 1'b1);
        check("post_rst_y_data", Y_data, 8'h11);
        check("post_rst_sel", Sel, 1'b0);
        Y_ready = 1'b1;
        step();
        exp_data.push_back(8'h11); exp_sel.push_back(1'b0);
        step();

        // Every word leaving Y, in order; the first eight on back-to-back cycles.
        check("log_count", got_data.size(), exp_data.size());
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            check($sformatf("log_data[%0d]", k), got_data[k], exp_data[k]);
            check($sformatf("log_sel[%0d]", k), got_sel[k], exp_sel[k]);
        end
        for (int k = 1; k < 8 && k < got_cyc.size(); k++)
            check($sformatf("stream_gap[%0d]", k), got_cyc[k] - got_cyc[k-1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
